// File: rtl/datapath_pkg.sv
// datapath_pkg: shared opcodes, flag bit positions and data width for the execution datapath.
package datapath_pkg;
    localparam int WIDTH = 16;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01011;
    localparam logic [4:0] OP_AND = 5'b00001;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_XOR = 5'b00011;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;
endpackage

// File: rtl/regfile_alu_datapath_alu_core.sv
// alu_core: combinational ALU producing result, next {C,L,F,Z,N} flags and an illegal-opcode strobe.
module alu_core
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags_nx,
    output logic             illegal
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             add_v, sub_v, lt, c, l, f, n;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = a - b;
    assign lt    = a < b;
    assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        c = 1'b0;
        l = 1'b0;
        f = 1'b0;
        case (opcode)
            OP_ADD:         begin result = sum[WIDTH-1:0]; c = sum[WIDTH]; f = add_v; end
            OP_SUB, OP_CMP: begin result = diff; c = lt; l = lt; f = sub_v; end
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            OP_MOV:         result = b;
            default:        illegal = 1'b1;
        endcase
        // signed A<B is the sign of the difference corrected by overflow
        n = (opcode == OP_SUB || opcode == OP_CMP) ? (diff[WIDTH-1] ^ sub_v) : result[WIDTH-1];
        flags_nx        = '0;
        flags_nx[FLG_C] = c;
        flags_nx[FLG_L] = l;
        flags_nx[FLG_F] = f;
        flags_nx[FLG_Z] = (result == '0);
        flags_nx[FLG_N] = n;
    end
endmodule

// File: rtl/regfile_alu_datapath.sv
// regfile_alu_datapath: 16x16 register file with multi-write fan-out, ALU and flag register.
module regfile_alu_datapath #(
    parameter int WIDTH = datapath_pkg::WIDTH,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rs,
    input  logic [3:0]       rd,
    input  logic [4:0]       opcode,
    input  logic [NREGS-1:0] re,
    input  logic             ri,
    input  logic             fe,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             illegal,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);
    import datapath_pkg::*;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [4:0]       flags_q, flags_d, flags_nx;
    logic [WIDTH-1:0] a, b;
    logic             we;

    assign a        = regs_q[rd];
    assign b        = ri ? imm : regs_q[rs];
    assign dbg_data = regs_q[dbg_sel];
    assign flags    = flags_q;
    assign we       = !illegal && opcode != OP_CMP;

    alu_core u_alu (
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .result   (result),
        .flags_nx (flags_nx),
        .illegal  (illegal)
    );

    always_comb begin
        for (int i = 0; i < NREGS; i++) regs_d[i] = (we && re[i]) ? result : regs_q[i];
        flags_d = (fe && !illegal) ? flags_nx : flags_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb_regfile_alu_datapath: directed vectors with hand-computed expectations for the datapath.
module tb_regfile_alu_datapath;
    import datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rs = '0, rd = '0, dbg_sel = '0;
    logic [4:0]  opcode = OP_MOV;
    logic [15:0] re = '0, imm = '0;
    logic        ri = 1'b0, fe = 1'b0;
    logic [15:0] result, dbg_data;
    logic [4:0]  flags;
    logic        illegal;
    logic [15:0] mdl [16];
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    regfile_alu_datapath dut (
        .clk(clk), .rst(rst), .rs(rs), .rd(rd), .opcode(opcode), .re(re), .ri(ri), .fe(fe),
        .imm(imm), .result(result), .flags(flags), .illegal(illegal), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            chk($sformatf("%s R%0d", tag, i), dbg_data, mdl[i]);
        end
    endtask

    initial begin
        // preload R1..R15 = FFFF; MOV with fe sets N so reset has something to clear
        opcode = OP_MOV; ri = 1'b1; imm = 16'hFFFF; re = 16'hFFFE; fe = 1'b1;
        tick;
        dbg_sel = 4'd7;
        #1;
        chk("preload R7", dbg_data, 16'hFFFF);
        chk("preload flags", {11'd0, flags}, 16'h0001);
        rst = 1'b0;
        tick;
        rst = 1'b1; re = '0; fe = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        chk_regs("reset");
        chk("reset flags", {11'd0, flags}, 16'h0000);

        // Fibonacci
        opcode = OP_ADD; rd = 4'd0; ri = 1'b1; imm = 16'd1; re = 16'h0002; fe = 1'b1;
        #1;
        chk("fib1 result", result, 16'd1);
        tick;
        chk("fib1 flags", {11'd0, flags}, 16'h0000);
        fe = 1'b0; ri = 1'b0; rd = 4'd1; rs = 4'd0; re = 16'h0004;
        tick;
        for (int n = 3; n <= 15; n++) begin
            rs = 4'(n - 2); rd = 4'(n - 1); re = 16'(1 << n);
            tick;
        end
        mdl[1] = 1;   mdl[2] = 1;   mdl[3] = 2;    mdl[4] = 3;    mdl[5] = 5;
        mdl[6] = 8;   mdl[7] = 13;  mdl[8] = 21;   mdl[9] = 34;   mdl[10] = 55;
        mdl[11] = 89; mdl[12] = 144; mdl[13] = 233; mdl[14] = 377; mdl[15] = 610;
        chk_regs("fib");
        chk("fib flags", {11'd0, flags}, 16'h0000);

        // CMP 5 vs 7: writes suppressed despite re=FFFF
        opcode = OP_CMP; rd = 4'd5; ri = 1'b1; imm = 16'd7; re = 16'hFFFF; fe = 1'b1;
        #1;
        chk("cmp result", result, 16'hFFFE);
        chk("cmp illegal", {15'd0, illegal}, 16'h0000);
        tick;
        chk("cmp flags", {11'd0, flags}, 16'h0019);
        chk_regs("cmp");

        // R6 = 8000 with fe=0, then SUB R6 - R1 into R4
        opcode = OP_MOV; ri = 1'b1; imm = 16'h8000; re = 16'h0040; fe = 1'b0;
        tick;
        mdl[6] = 16'h8000;
        chk("mov hold flags", {11'd0, flags}, 16'h0019);
        opcode = OP_SUB; rd = 4'd6; rs = 4'd1; ri = 1'b0; re = 16'h0010; fe = 1'b1;
        dbg_sel = 4'd4;
        #1;
        chk("sub result", result, 16'h7FFF);
        tick;
        mdl[4] = 16'h7FFF;
        chk("sub R4", dbg_data, 16'h7FFF);
        chk("sub flags", {11'd0, flags}, 16'h0005);

        // Multi-write, no write-through before the edge
        opcode = OP_MOV; ri = 1'b1; imm = 16'h00A5; re = 16'h0F00; fe = 1'b0; dbg_sel = 4'd8;
        #1;
        chk("mov pre-edge R8", dbg_data, 16'd21);
        tick;
        mdl[8] = 16'h00A5; mdl[9] = 16'h00A5; mdl[10] = 16'h00A5; mdl[11] = 16'h00A5;
        chk_regs("mov");
        chk("mov flags", {11'd0, flags}, 16'h0005);

        // Illegal opcode
        opcode = 5'b11111; rd = 4'd1; ri = 1'b1; imm = 16'h1234; re = 16'h0008; fe = 1'b1;
        #1;
        chk("ill illegal", {15'd0, illegal}, 16'h0001);
        chk("ill result", result, 16'h0000);
        tick;
        dbg_sel = 4'd3;
        #1;
        chk("ill R3", dbg_data, 16'd2);
        chk("ill flags", {11'd0, flags}, 16'h0005);

        // Reset on the same edge as an ADD write with fe
        opcode = OP_ADD; rd = 4'd1; ri = 1'b1; imm = 16'd1; re = 16'h0020; fe = 1'b1; rst = 1'b0;
        tick;
        rst = 1'b1; re = '0; fe = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        chk_regs("midrst");
        chk("midrst flags", {11'd0, flags}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
- Execution datapath that consumes the per-cycle control bundle from the sequencing FSM: rs, rd, opcode, re, ri, fe, imm.
- Contains a 16x16 register file, a combinational ALU and a 5-bit flag register.
- Operand A = R[rd]; operand B = imm when ri=1, else R[rs].
- On each rising clk edge the ALU result is written to every register whose re bit is set; flags update when fe=1.

Parameters:
- WIDTH, 16, data/register/immediate width.
- NREGS, 16, register count; fixed to match the 4-bit selects and 16-bit re.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rs  in  4  source select (operand B when ri=0)
- rd  in  4  operand A select
- opcode  in  5  ALU operation
- re  in  16  per-register write enable, bit n writes Rn
- ri  in  1  1 = operand B from imm
- fe  in  1  1 = flag register updates this cycle
- imm  in  16  immediate operand
- result  out  16  combinational ALU output
- flags  out  5  registered {C,L,F,Z,N}
- illegal  out  1  combinational; high when opcode is not in the decoded set
- dbg_sel  in  4  debug read select
- dbg_data  out  16  combinational R[dbg_sel]

Behaviour:
- Reset: on posedge clk with rst=0, all 16 registers <= 0 and flags <= 0. Reset overrides any re/fe in the same cycle.
- Read timing:
  - Reads are combinational from current contents.
  - A register written at edge k is visible on operand paths and dbg_data only after edge k (no write-through).
- Write:
  - The same result goes to all set re bits; one-hot is not required.
  - re=0 means no write.
  - R0 is an ordinary writable register.
- Opcodes (A=R[rd], B=ri?imm:R[rs], all arithmetic mod 2^16):
  - 00101 ADD: A+B
  - 01001 SUB: A-B
  - 01011 CMP: result=A-B, but all register writes are suppressed regardless of re
  - 00001 AND
  - 00010 OR
  - 00011 XOR
  - 01101 MOV: result=B
- Illegal opcode (any other code): result=0, illegal=1, register writes suppressed, flags held even if fe=1.
- Flags, computed from the current cycle's ops and latched at the edge when fe=1 and the opcode is legal:
  - C: ADD carry out of bit 15; SUB/CMP borrow (A<B unsigned); else 0.
  - L: SUB/CMP A<B unsigned; else 0.
  - F: ADD/SUB/CMP signed overflow; else 0.
  - Z: result==0 (CMP: A==B).
  - N: CMP/SUB signed A<B; other ops result[15].
- fe=0: flags hold. A register write and a flag update in the same cycle are independent.
- Latency: result and illegal are combinational (0 cycles); register and flag effects take 1 cycle.
- Mid-operation reset: whatever the bundle is, the next edge leaves all registers and flags at 0. The datapath holds no pending state.

Decomposition:
- Shared package (datapath_pkg): opcode localparams (OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV), flag bit indices (FLG_C=4, FLG_L=3, FLG_F=2, FLG_Z=1, FLG_N=0), WIDTH.
- Sub-module: alu_core, purely combinational. Inputs a, b, opcode; outputs result, next-flag vector, illegal. The register file, write fan-out and flag register stay in the top module.

Test Plan:
- Reset: preload R1..R15 = 16'hFFFF, drive rst=0 for one edge -> every dbg_data read = 0, flags = 0.
- Fibonacci (one edge per step, fe=1 only on the first):
  - Step 1: opcode=ADD, rd=0, ri=1, imm=1, re[1]=1.
  - Step 2: rd=1, rs=0, re[2]=1.
  - Following steps: rs=n-2, rd=n-1, re[n]=1 for n=3..15.
  - Required: R1..R15 = 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610.
  - Required: flags = 5'b00000 after step 1 and unchanged through step 15.
- Compare and subtract with fe=1:
  - CMP, R[rd]=5, imm=7, ri=1, re=16'hFFFF -> no register changes; flags C=1, L=1, F=0, Z=0, N=1.
  - SUB, R[rd]=16'h8000, R[rs]=1, re[4]=1 -> R4=16'h7FFF; flags C=0, L=0, F=1, Z=0, N=1.
- Multi-write and flag hold: MOV, ri=1, imm=16'h00A5, re=16'h0F00, fe=0 -> R8..R11 = 16'h00A5; flags unchanged.
- Illegal opcode: opcode=5'b11111, re[3]=1, fe=1 -> illegal=1, result=0, R3 and flags unchanged.
- Reset mid-operation: rst=0 on the same edge as an ADD with re[5]=1, fe=1 -> R5=0, flags=0 after that edge.
